// File: rtl/hongwai_uart_report_pkg.sv
// Shared constants, state encoding and frame-byte helper for the hongwai UART status reporter.
package hongwai_uart_report_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES    = 3;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Byte 2 is a simple XOR checksum of the header and payload bytes.
    function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                              input logic [7:0] header,
                                              input logic [1:0] payload);
        logic [7:0] result;
        case (idx)
            2'd0:    result = header;
            2'd1:    result = {6'b0, payload};
            default: result = header ^ {6'b0, payload};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/hongwai_uart_report_uart_tx_byte.sv
// 8N1 byte transmitter; a start pulse at the end of a stop bit chains the next byte with no gap.
module hongwai_uart_report_uart_tx_byte
    import hongwai_uart_report_pkg::*;
#(
    parameter int BPS_CNT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    tx_state_t   state;
    tx_state_t   next_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        bit_end;
    logic        load;

    assign bit_end = (bit_cnt == 16'(BPS_CNT - 1));
    assign load    = start && ((state == IDLE) || done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = START;
                end
            end
            START: begin
                if (bit_end) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done       = 1'b1;
                    next_state = start ? START : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
        end else begin
            if ((state == IDLE) || bit_end) begin
                bit_cnt <= 16'd0;
            end else begin
                bit_cnt <= bit_cnt + 16'd1;
            end
            if (state == START) begin
                bit_idx <= 3'd0;
            end else if ((state == DATA) && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (load) begin
                shift <= data;
            end
        end
    end

    // Line outputs are registered from the current state, so the wire lags the FSM by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx   <= 1'b1;
            busy <= 1'b0;
        end else begin
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[bit_idx];
                default: tx <= 1'b1;
            endcase
            busy <= (state != IDLE);
        end
    end

endmodule

// File: rtl/hongwai_uart_report.sv
// Reports every change of the bump/dip classification as a 3-byte UART frame: header, payload, checksum.
module hongwai_uart_report
    import hongwai_uart_report_pkg::*;
#(
    parameter int         BPS_CNT = 5208,
    parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] flag_tu_ao,
    output logic       tx,
    output logic       tx_busy,
    output logic [7:0] frame_cnt
);

    logic [1:0] flag_q;
    logic [1:0] last_sent;
    logic [1:0] payload;
    logic [1:0] byte_idx;
    logic       active;
    logic       launch;
    logic       byte_done;
    logic       byte_start;
    logic [1:0] byte_sel;
    logic [7:0] byte_data;

    // Changes are ignored while a frame is in flight; the compare resumes once it ends.
    assign launch     = !active && (flag_q != last_sent);
    assign byte_start = launch || (byte_done && (byte_idx != LAST_BYTE_IDX));
    assign byte_sel   = launch ? 2'd0 : (byte_idx + 2'd1);
    assign byte_data  = frame_byte(byte_sel, HEADER, payload);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= 2'b00;
            last_sent <= 2'b00;
            payload   <= 2'b00;
            byte_idx  <= 2'd0;
            active    <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            flag_q <= flag_tu_ao;
            if (launch) begin
                payload   <= flag_q;
                last_sent <= flag_q;
                byte_idx  <= 2'd0;
                active    <= 1'b1;
            end else if (byte_done) begin
                if (byte_idx != LAST_BYTE_IDX) begin
                    byte_idx <= byte_idx + 2'd1;
                end else begin
                    active    <= 1'b0;
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    hongwai_uart_report_uart_tx_byte #(
        .BPS_CNT (BPS_CNT)
    ) u_tx_byte (
        .clk   (clk),
        .rst_n (rst_n),
        .start (byte_start),
        .data  (byte_data),
        .tx    (tx),
        .busy  (tx_busy),
        .done  (byte_done)
    );

endmodule

// File: doc/hongwai_uart_report.md
Name: hongwai_uart_report

Overview:
- Downstream stage of the infrared receive path. Consumes the 2-bit bump/dip classification `flag_tu_ao` produced by the hongwai receiver.
- Whenever the classification changes, transmits a 3-byte status frame on a UART TX line, 8N1 at 9600 baud.
- Contains its own bit-period counter and shift logic. Lets a host log terrain events over the same serial link family as the receive side.

Parameters:
- BPS_CNT, 5208, clocks per UART bit (50 MHz / 9600); legal range 4..65535.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, single domain.
- rst_n  input  1  asynchronous active-low reset.
- flag_tu_ao  input  2  classification from hongwai receiver; synchronous to clk.
- tx  output  1  UART serial output, idle high.
- tx_busy  output  1  high while a frame is on the line.
- frame_cnt  output  8  count of completed frames; wraps 255->0.

Behaviour:
- Reset values (async, asserted when rst_n is low):
  - tx=1, tx_busy=0, frame_cnt=0.
  - Internal: flag_q=2'b00, last_sent=2'b00, state=IDLE, bit and byte counters=0.
- Input handling: flag_tu_ao is registered into flag_q every cycle, with no further synchronisation.
- Frame content:
  - byte0 = HEADER.
  - byte1 = {6'b0, payload}.
  - byte2 = byte0 XOR byte1.
  - Each byte is sent as a start bit (0), 8 data bits LSB first, then a stop bit (1). Each bit lasts exactly BPS_CNT clocks.
  - The three bytes are back-to-back with no gap: 30 bit times per frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: each cycle, if flag_q != last_sent, then payload<=flag_q, last_sent<=flag_q, byte_idx<=0, go to START. Otherwise stay.
  - START: tx=0 for BPS_CNT clocks, then go to DATA with bit_idx=0.
  - DATA: tx=shift[bit_idx]. After BPS_CNT clocks, increment bit_idx. When bit 7 completes, go to STOP.
  - STOP: tx=1 for BPS_CNT clocks. Then:
    - if byte_idx<2: increment byte_idx and go to START;
    - otherwise: frame_cnt+1 and go to IDLE.
- Latency: a flag_tu_ao change sampled at edge N sets flag_q at N. The FSM leaves IDLE at N+1, and tx falls (registered) at edge N+2.
- tx_busy:
  - Rises in the same cycle tx first falls.
  - Falls in the same cycle the FSM re-enters IDLE, after the final stop bit's BPS_CNT clocks.
- The bit counter runs only outside IDLE and clears on every bit boundary and in IDLE.
- Boundary conditions:
  - Flag changes during a frame: the payload is not altered. The comparison resumes on return to IDLE, so multiple changes collapse to one frame carrying the latest value.
  - Flag changes and returns to last_sent before the frame ends: no new frame is sent.
  - Flag differs on the IDLE re-entry cycle: the next frame starts immediately, giving a minimum inter-frame idle of 1 clock at tx=1.
  - After reset, a frame is sent only if flag_q becomes nonzero.
  - frame_cnt wraps 255->0 without saturation.
  - rst_n asserted mid-frame: tx goes high immediately, and the partial frame is abandoned.
- tx is driven from a flop, never combinationally.

Decomposition:
- Shared package holds:
  - the HEADER default;
  - state encoding localparams: IDLE=0, START=1, DATA=2, STOP=3;
  - the frame length constant: 3 bytes.
- One sub-module is natural: uart_tx_byte.
  - Owns the bit-period counter and the start/data/stop sequencing.
  - Interface: start pulse plus 8-bit data in; tx and a done pulse out.
- The top holds change detection, byte sequencing, checksum and frame_cnt.

Test Plan:
All scenarios use BPS_CNT=16, so a bit is 16 clocks and a frame is 480 clocks.
1. Reset, then hold flag_tu_ao=00 for 1000 clocks -> tx stays 1, tx_busy=0, frame_cnt=0.
2. Step flag_tu_ao 00->01 -> tx falls 2 edges later. The decoded bytes are A5, 01, A4. tx_busy is high for exactly 480 clocks, and frame_cnt=1.
3. During scenario 2's frame, drive flag 01->10->11 -> the first frame is unaltered, then immediately one frame A5, 03, A6 follows, and frame_cnt=2.
4. From last_sent=11, pulse flag to 10 for 50 clocks mid-frame, then back to 11 -> no additional frame, and tx_busy falls after the current frame.
5. Assert rst_n low at clock 200 of a frame -> tx=1 and tx_busy=0 within the same cycle, with counters cleared. After release, flag=10 produces a full frame A5, 02, A7.
6. Drive 256 alternating flag changes, each waiting for idle -> frame_cnt reads 0 after the 256th frame (wrap).
